// File: rtl/slv_sched_pkg.sv
// Shared types and the round-robin selection rule for the slave burst scheduler.
package slv_sched_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} sched_state_t;

  localparam int MODE_W  = 2;
  localparam int PVAL_W  = 8;
  localparam int MAX_SLV = 8;

  // Index of the first set req bit strictly after last, wrapping modulo nslv.
  function automatic logic [2:0] rr_pick(input logic [MAX_SLV-1:0] req,
                                         input int nslv,
                                         input logic [2:0] last);
    int idx;
    rr_pick = last;
    // Scan from the farthest offset down so the nearest requester wins.
    for (int k = MAX_SLV; k >= 1; k--) begin
      if (k <= nslv) begin
        idx = (int'(last) + k) % nslv;
        if (req[idx]) rr_pick = 3'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/slv_burst_scheduler_rr_picker.sv
// Combinational round-robin picker: next requester after last_grant.
module rr_picker
  import slv_sched_pkg::*;
#(
  parameter int NSLV = 2,
  parameter int IW   = 1
) (
  input  logic [NSLV-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [MAX_SLV-1:0] req_ext;
  logic [2:0]         pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NSLV-1:0]  = req;
    pick               = rr_pick(req_ext, NSLV, 3'(last_grant));
  end

  assign gnt_idx = IW'(pick);
  assign gnt_any = |req;

endmodule

// File: rtl/slv_burst_scheduler.sv
// Round-robin burst scheduler sharing one processing-FIFO write path among NSLV slave channels.
module slv_burst_scheduler
  import slv_sched_pkg::*;
#(
  parameter int DW        = 32,
  parameter int NSLV      = 2,
  parameter int BURST_LEN = 16,
  parameter int TMO       = 8,
  parameter int IW        = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSLV-1:0]          slv_data_valid,
  input  logic [MODE_W*NSLV-1:0]   slv_mode,
  input  logic [DW*NSLV-1:0]       slv_data,
  input  logic [PVAL_W*NSLV-1:0]   slv_proc_val,
  output logic [NSLV-1:0]          slv_ready,
  input  logic                     fifo_full,
  input  logic                     mstr_cmplt,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [MODE_W-1:0]        out_mode,
  output logic [PVAL_W-1:0]        out_proc_val,
  output logic [IW-1:0]            out_src,
  output logic                     busy
);

  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int TCW = $clog2(TMO + 1);

  sched_state_t       state_q;
  logic [IW-1:0]      last_grant_q;
  logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [TCW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               path_open, g_valid, xfer;
  logic [DW-1:0]      g_data;
  logic [MODE_W-1:0]  pick_mode;
  logic [PVAL_W-1:0]  pick_pval;

  rr_picker #(.NSLV(NSLV), .IW(IW)) u_picker (
    .req        (slv_data_valid),
    .last_grant (last_grant_q),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign path_open  = (state_q == BURST) & ~fifo_full & ~mstr_cmplt;
  assign xfer       = path_open & g_valid;
  assign beat_cnt_d = beat_cnt_q + 1'b1;
  assign tmo_cnt_d  = tmo_cnt_q + 1'b1;

  // out_src doubles as the grant register: it selects the live channel in BURST.
  always_comb begin
    g_data    = '0;
    g_valid   = 1'b0;
    pick_mode = '0;
    pick_pval = '0;
    slv_ready = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (out_src == IW'(i)) begin
        g_data       = slv_data[i*DW +: DW];
        g_valid      = slv_data_valid[i];
        slv_ready[i] = path_open;
      end
      if (gnt_idx == IW'(i)) begin
        pick_mode = slv_mode[i*MODE_W +: MODE_W];
        pick_pval = slv_proc_val[i*PVAL_W +: PVAL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NSLV - 1);
      beat_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_mode     <= '0;
      out_proc_val <= '0;
      out_src      <= '0;
      busy         <= 1'b0;
    end else begin
      out_valid <= xfer;
      if (xfer) out_data <= g_data;
      case (state_q)
        IDLE: begin
          if (~mstr_cmplt & gnt_any) begin
            state_q      <= BURST;
            busy         <= 1'b1;
            out_src      <= gnt_idx;
            out_mode     <= pick_mode;
            out_proc_val <= pick_pval;
            beat_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
          end
        end
        BURST: begin
          if (mstr_cmplt) begin
            state_q      <= IDLE;
            busy         <= 1'b0;
            last_grant_q <= out_src;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_d;
            tmo_cnt_q  <= '0;
            if (beat_cnt_d == BCW'(BURST_LEN)) begin
              state_q      <= IDLE;
              busy         <= 1'b0;
              last_grant_q <= out_src;
            end
          end else if (~fifo_full & ~g_valid) begin
            // Stalls freeze the idle counter; only a silent, unstalled channel ages it.
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_cnt_d == TCW'(TMO)) begin
              state_q      <= IDLE;
              busy         <= 1'b0;
              last_grant_q <= out_src;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slv_burst_scheduler.sv
// Self-checking bench for slv_burst_scheduler: directed scenarios plus a randomized run against a reference model.
module tb_slv_burst_scheduler;
  localparam int DW = 32, NSLV = 3, BL = 16, TMO = 8, IW = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NSLV-1:0]     slv_data_valid = '0;
  logic [2*NSLV-1:0]   slv_mode = '0;
  logic [DW*NSLV-1:0]  slv_data = '0;
  logic [8*NSLV-1:0]   slv_proc_val = '0;
  logic [NSLV-1:0]     slv_ready;
  logic                fifo_full = 1'b0;
  logic                mstr_cmplt = 1'b0;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [1:0]          out_mode;
  logic [7:0]          out_proc_val;
  logic [IW-1:0]       out_src;
  logic                busy;

  slv_burst_scheduler #(.DW(DW), .NSLV(NSLV), .BURST_LEN(BL), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .slv_data_valid(slv_data_valid), .slv_mode(slv_mode),
    .slv_data(slv_data), .slv_proc_val(slv_proc_val), .slv_ready(slv_ready),
    .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt), .out_valid(out_valid),
    .out_data(out_data), .out_mode(out_mode), .out_proc_val(out_proc_val),
    .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int             n_chk = 0, n_fail = 0;
  int             rem [NSLV];
  logic [DW-1:0]  dat [NSLV];
  logic [1:0]     md  [NSLV];
  logic [7:0]     pv  [NSLV];
  logic [NSLV-1:0] hs;

  // Channel sources: valid while beats remain, data advances on each accepted beat.
  task automatic settle();
    for (int i = 0; i < NSLV; i++) begin
      slv_data_valid[i]        = (rem[i] > 0);
      slv_data[i*DW +: DW]     = dat[i];
      slv_mode[2*i +: 2]       = md[i];
      slv_proc_val[8*i +: 8]   = pv[i];
    end
    #1;
  endtask

  task automatic cyc();
    hs = rst ? '0 : (slv_data_valid & slv_ready);
    @(posedge clk); #1;
    for (int i = 0; i < NSLV; i++)
      if (hs[i]) begin dat[i] = dat[i] + 1; rem[i] = rem[i] - 1; end
    settle();
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_full = 1'b0; mstr_cmplt = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      rem[i] = 0; dat[i] = DW'(i) << 16; md[i] = 2'(i + 1); pv[i] = 8'(8'h30 + i);
    end
    settle(); cyc(); cyc();
    rst = 1'b0; settle();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; rem[0] = 5; rem[1] = 5; settle(); cyc(); cyc();
    n_chk++;
    if ({out_valid, out_data, out_mode, out_proc_val, out_src, busy, slv_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h mode=%0d pval=%h src=%0d busy=%b rdy=%b, expected all 0",
               out_valid, out_data, out_mode, out_proc_val, out_src, busy, slv_ready);
    end
    rst = 1'b0; settle();
  endtask

  task automatic test_single_ch();
    logic exp_ov, exp_busy; logic [DW-1:0] exp_d; logic [NSLV-1:0] exp_rdy;
    do_reset();
    rem[0] = 20; md[0] = 2'd2; pv[0] = 8'h5A; settle();
    for (int n = 1; n <= 31; n++) begin
      cyc();
      exp_ov   = (n >= 2 && n <= 17) || (n >= 19 && n <= 22);
      exp_d    = (n <= 17) ? DW'(n - 2) : DW'(n - 3);
      exp_busy = (n <= 16) || (n >= 18 && n <= 29);
      exp_rdy  = exp_busy ? NSLV'(1) : '0;
      n_chk++;
      if ({busy, out_valid, slv_ready} !== {exp_busy, exp_ov, exp_rdy} || (exp_ov && out_data !== exp_d)) begin
        n_fail++;
        $display("FAIL single_ch cyc%0d: got busy=%b ov=%b rdy=%b data=%0d, expected busy=%b ov=%b rdy=%b data=%0d",
                 n, busy, out_valid, slv_ready, out_data, exp_busy, exp_ov, exp_rdy, exp_d);
      end
      if (exp_busy) begin
        n_chk++;
        if ({out_src, out_mode, out_proc_val} !== {IW'(0), 2'd2, 8'h5A}) begin
          n_fail++;
          $display("FAIL single_ch_latch cyc%0d: got src=%0d mode=%0d pval=%h, expected 0/2/5a",
                   n, out_src, out_mode, out_proc_val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int p, b, src; logic exp_ov, exp_busy; logic [DW-1:0] exp_d; logic [NSLV-1:0] exp_rdy;
    do_reset();
    rem[0] = 32; rem[1] = 32; settle();
    for (int n = 1; n <= 68; n++) begin
      cyc();
      p = (n - 1) % 17; b = (n - 1) / 17; src = b % 2;
      exp_busy = (p != 16);
      exp_ov   = (p != 0);
      exp_d    = (DW'(src) << 16) + DW'(16 * (b / 2) + p - 1);
      exp_rdy  = exp_busy ? (NSLV'(1) << src) : '0;
      n_chk++;
      if ({busy, out_valid, slv_ready} !== {exp_busy, exp_ov, exp_rdy} || (exp_ov && out_data !== exp_d) ||
          (exp_busy && out_src !== IW'(src))) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got busy=%b ov=%b rdy=%b data=%h src=%0d, expected busy=%b ov=%b rdy=%b data=%h src=%0d",
                 n, busy, out_valid, slv_ready, out_data, out_src, exp_busy, exp_ov, exp_rdy, exp_d, src);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic exp_ov, exp_busy, exp_rdy; logic [DW-1:0] exp_d;
    do_reset();
    rem[0] = 16; settle();
    for (int n = 1; n <= 23; n++) begin
      fifo_full = (n >= 6 && n <= 10); settle();
      exp_rdy = (n >= 2 && n <= 22 && !fifo_full);
      n_chk++;
      if (slv_ready !== {{(NSLV-1){1'b0}}, exp_rdy}) begin
        n_fail++;
        $display("FAIL fifo_full_ready cyc%0d: got rdy=%b, expected rdy0=%b", n, slv_ready, exp_rdy);
      end
      cyc();
      exp_ov   = (n >= 2 && n <= 5) || (n >= 11 && n <= 22);
      exp_d    = (n <= 5) ? DW'(n - 2) : DW'(n - 7);
      exp_busy = (n <= 21);
      n_chk++;
      if ({busy, out_valid} !== {exp_busy, exp_ov} || (exp_ov && out_data !== exp_d)) begin
        n_fail++;
        $display("FAIL fifo_full cyc%0d: got busy=%b ov=%b data=%0d, expected busy=%b ov=%b data=%0d",
                 n, busy, out_valid, out_data, exp_busy, exp_ov, exp_d);
      end
    end
    fifo_full = 1'b0; settle();
  endtask

  task automatic test_timeout();
    logic exp_ov, exp_busy; logic [DW-1:0] exp_d; int src;
    do_reset();
    rem[1] = 3; settle();
    for (int n = 1; n <= 16; n++) begin
      if (n == 5) begin rem[0] = 2; settle(); end
      cyc();
      exp_busy = (n <= 11) || (n >= 13);
      src      = (n <= 11) ? 1 : 0;
      exp_ov   = (n >= 2 && n <= 4) || n == 14 || n == 15;
      exp_d    = (n <= 4) ? (DW'(1) << 16) + DW'(n - 2) : DW'(n - 14);
      n_chk++;
      if ({busy, out_valid} !== {exp_busy, exp_ov} || (exp_ov && out_data !== exp_d) ||
          (exp_busy && out_src !== IW'(src))) begin
        n_fail++;
        $display("FAIL timeout cyc%0d: got busy=%b ov=%b data=%h src=%0d, expected busy=%b ov=%b data=%h src=%0d",
                 n, busy, out_valid, out_data, out_src, exp_busy, exp_ov, exp_d, src);
      end
    end
  endtask

  task automatic test_mstr_cmplt();
    logic exp_ov, exp_busy, exp_rdy; logic [DW-1:0] exp_d;
    do_reset();
    rem[0] = 20; settle();
    for (int n = 1; n <= 14; n++) begin
      mstr_cmplt = (n >= 9 && n <= 12); settle();
      exp_rdy = (n >= 2 && n <= 8) || n == 14;
      n_chk++;
      if (slv_ready !== {{(NSLV-1){1'b0}}, exp_rdy}) begin
        n_fail++;
        $display("FAIL mstr_ready cyc%0d: got rdy=%b, expected rdy0=%b", n, slv_ready, exp_rdy);
      end
      cyc();
      exp_busy = (n <= 8) || (n >= 13);
      exp_ov   = (n >= 2 && n <= 8) || n == 14;
      exp_d    = (n <= 8) ? DW'(n - 2) : DW'(7);
      n_chk++;
      if ({busy, out_valid} !== {exp_busy, exp_ov} || (exp_ov && out_data !== exp_d)) begin
        n_fail++;
        $display("FAIL mstr_cmplt cyc%0d: got busy=%b ov=%b data=%0d, expected busy=%b ov=%b data=%0d",
                 n, busy, out_valid, out_data, exp_busy, exp_ov, exp_d);
      end
    end
    mstr_cmplt = 1'b0; settle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[0] = 30; rem[1] = 30; settle();
    for (int n = 1; n <= 13; n++) begin
      rst = (n == 12); settle();
      cyc();
      if (n >= 2 && n <= 11) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== DW'(n - 2)) begin
          n_fail++;
          $display("FAIL pre_reset_beat cyc%0d: got ov=%b data=%0d, expected ov=1 data=%0d", n, out_valid, out_data, n - 2);
        end
      end
    end
    // Cycle 12 was the reset edge; cycle 13 regrants with channel 0 first in line.
    n_chk++;
    if ({busy, out_valid, out_src} !== {1'b1, 1'b0, IW'(0)}) begin
      n_fail++;
      $display("FAIL reset_regrant: got busy=%b ov=%b src=%0d, expected busy=1 ov=0 src=0", busy, out_valid, out_src);
    end
    rst = 1'b1; settle(); cyc();
    n_chk++;
    if ({out_valid, out_data, out_mode, out_proc_val, out_src, busy, slv_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: got ov=%b data=%h mode=%0d pval=%h src=%0d busy=%b rdy=%b, expected all 0",
               out_valid, out_data, out_mode, out_proc_val, out_src, busy, slv_ready);
    end
    rst = 1'b0; settle();
  endtask

  task automatic test_random();
    logic [NSLV-1:0] en, req, exp_rdy;
    logic bb, pre, xf, mcs, ffs, found;
    int lg, gsrc, sel, beats, idle;
    logic [1:0] em, gm; logic [7:0] ep, gp; logic [DW-1:0] ed;
    do_reset();
    en = '1; bb = 1'b0; lg = NSLV - 1; gsrc = 0; beats = 0; idle = 0; em = '0; ep = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NSLV; i++) begin
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
        rem[i] = (en[i] && $urandom_range(0, 3) != 0) ? 1 : 0;
        md[i]  = 2'($urandom);
        pv[i]  = 8'($urandom);
      end
      fifo_full  = ($urandom_range(0, 9) == 0);
      mstr_cmplt = ($urandom_range(0, 39) == 0);
      settle();
      exp_rdy = '0;
      if (bb && !fifo_full && !mstr_cmplt) exp_rdy[gsrc] = 1'b1;
      n_chk++;
      if (slv_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready c%0d: got %b, expected %b", c, slv_ready, exp_rdy);
      end
      pre = bb; req = slv_data_valid; mcs = mstr_cmplt; ffs = fifo_full;
      sel = 0; found = 1'b0;
      for (int k = 1; k <= NSLV; k++)
        if (!found && req[(lg + k) % NSLV]) begin sel = (lg + k) % NSLV; found = 1'b1; end
      gm = md[sel]; gp = pv[sel]; ed = dat[gsrc];
      xf = pre && !ffs && !mcs && req[gsrc];
      cyc();
      if (!pre) begin
        if (!mcs && found) begin bb = 1'b1; gsrc = sel; beats = 0; idle = 0; em = gm; ep = gp; end
      end else if (mcs) begin
        bb = 1'b0; lg = gsrc;
      end else if (xf) begin
        beats++; idle = 0;
        if (beats == BL) begin bb = 1'b0; lg = gsrc; end
      end else if (!ffs) begin
        idle++;
        if (idle == TMO) begin bb = 1'b0; lg = gsrc; end
      end
      n_chk++;
      if ({busy, out_valid} !== {bb, xf} || (xf && out_data !== ed) ||
          (bb && {out_src, out_mode, out_proc_val} !== {IW'(gsrc), em, ep})) begin
        n_fail++;
        $display("FAIL rand_out c%0d: got busy=%b ov=%b data=%h src=%0d mode=%0d pval=%h, expected busy=%b ov=%b data=%h src=%0d mode=%0d pval=%h",
                 c, busy, out_valid, out_data, out_src, out_mode, out_proc_val, bb, xf, ed, gsrc, em, ep);
      end
    end
    fifo_full = 1'b0; mstr_cmplt = 1'b0; settle();
  endtask

  initial begin
    test_reset();
    test_single_ch();
    test_back_to_back();
    test_fifo_full();
    test_timeout();
    test_mstr_cmplt();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/slv_burst_scheduler.md
Name: slv_burst_scheduler

Overview:
- Round-robin burst scheduler that shares the single processing-FIFO write path between NSLV slave pixel channels.
- Each channel carries mode, data, proc_val and valid.
- One channel at a time holds the path for a burst of up to BURST_LEN beats. Per-burst mode and proc_val are latched. Beats are forwarded as a registered stream.
- Sits between the slave channel front-ends and the processing FIFO; stalls on fifo_full and on the master-complete signal.

Parameters:
- DW, 32, pixel data width per beat
- NSLV, 2, number of slave channels (2..8)
- BURST_LEN, 16, max beats per grant
- TMO, 8, idle cycles (granted channel not valid) before the grant is released
- IW, $clog2(NSLV) (min 1), source index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- slv_data_valid  in  NSLV  per-channel beat valid
- slv_mode  in  2*NSLV  per-channel mode; channel i at [2i+1:2i]
- slv_data  in  DW*NSLV  per-channel data; channel i at [DW*i+DW-1:DW*i]
- slv_proc_val  in  8*NSLV  per-channel processing value
- slv_ready  out  NSLV  per-channel accept, one-hot or zero
- fifo_full  in  1  downstream FIFO full
- mstr_cmplt  in  1  master reports frame complete; abort/stall
- out_valid  out  1  registered beat valid to FIFO
- out_data  out  DW  registered beat data
- out_mode  out  2  latched burst mode
- out_proc_val  out  8  latched burst proc_val
- out_src  out  IW  granted channel index
- busy  out  1  high in BURST state

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; beat_cnt = 0; tmo_cnt = 0.
  - last_grant = NSLV-1, so channel 0 has first priority.
  - out_valid, out_data, out_mode, out_proc_val, out_src and busy go to 0.
  - Reset mid-burst drops the burst with no further out_valid.
- slv_ready is combinational: slv_ready[g] = (state==BURST) & ~fifo_full & ~mstr_cmplt, for the granted g only. All other bits are 0, and all bits are 0 in IDLE.
- Beat transfer means slv_data_valid[g] & slv_ready[g] at a clk edge.
- IDLE:
  - If ~mstr_cmplt and any slv_data_valid bit is set, grant the first valid channel scanning from last_grant+1 upward, modulo NSLV.
  - On grant: latch g into out_src, slv_mode[g] into out_mode, slv_proc_val[g] into out_proc_val. Clear beat_cnt and tmo_cnt. Go to BURST.
  - No beat transfers in the grant cycle, so grant-to-first-accept latency is 1 cycle.
- BURST:
  - On each transfer: out_valid=1 and out_data=slv_data[g] on the next cycle (1-cycle latency); beat_cnt++; tmo_cnt cleared.
  - With no transfer, out_valid=0 next cycle.
  - tmo_cnt increments only when slv_data_valid[g]=0 and the path is not stalled. It holds while fifo_full or mstr_cmplt is high.
- BURST exit, all going to IDLE with last_grant = g:
  - (a) The transfer that makes beat_cnt==BURST_LEN.
  - (b) tmo_cnt reaches TMO.
  - (c) mstr_cmplt high: immediate abort, and no transfer that cycle.
- Mode and proc_val changes on the granted channel mid-burst are ignored until the next grant.
- fifo_full: no accept, beat_cnt holds, no out_valid; the grant is held indefinitely.
- Simultaneous valids in IDLE: strictly round-robin by last_grant; a channel cannot win twice in a row while another is valid.
- The back-to-back regrant IDLE cycle costs one bubble. out_valid is never high in an IDLE cycle except for the final beat's registered output.

Decomposition:
- Package slv_sched_pkg:
  - state enum sched_state_t {IDLE, BURST}
  - MODE_W=2, PVAL_W=8
  - function rr_pick(req, last) returning the next index
- Sub-module rr_picker (combinational, NSLV param):
  - inputs req[NSLV], last_grant
  - outputs gnt_idx, gnt_any
- The top holds the FSM, the counters and the output registers.

Test Plan:
- Reset then ch0 valid for 20 cycles with data 0..19, mode=2, proc_val=0x5A -> 16 out_valid beats with data 0..15, out_mode=2, out_proc_val=0x5A, out_src=0; IDLE for 1 cycle; new grant to ch0 (only requester); beats 16..19 follow.
- ch0 and ch1 valid continuously -> grants alternate 0,1,0,1, each 16 beats; slv_ready is never high on both channels.
- fifo_full pulsed high 5 cycles at beat 4 -> slv_ready=0 and no out_valid for those 5 cycles; beat_cnt holds; the burst still totals 16 beats; no timeout.
- ch1 granted, sends 3 beats, then valid drops -> release after exactly TMO=8 idle cycles; last_grant=1; a pending ch0 request is granted the next cycle.
- mstr_cmplt asserted at beat 7 -> slv_ready=0 the same cycle; state IDLE next cycle; no grant while mstr_cmplt is high.
- rst asserted at beat 10 -> all outputs 0 next cycle; after release ch0 wins against simultaneous ch1.
